div_32: RTL

Sequential 32-bit signed integer divider for the multiply/divide unit. It is the inverse counterpart of the unit's multiply path: it consumes the same operand buses and produces quotient, remainder, exception and a one-cycle ready pulse. It uses a restoring radix-2 algorithm that resolves one quotient bit per cycle, built around a single shared subtract step. It sits beside the multiplier and drives the same result/ready/exception outputs toward the register-writeback logic.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/div_32_if.sv | 30 +++
 rtl/div_32_step.sv | 23 ++
 rtl/div_32.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types, constants and helpers for the multiply/divide unit.
// Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    localparam int               WIDTH   = 32;
    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
    localparam int               CNT_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return '0 - v;
    endfunction

    // |INT_MIN| wraps back to 0x80000000, which the unsigned datapath reads as 2^31.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg(v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_32_if.sv
`default_nettype none
// ============================================================================
// Module   : div_32_if
// Purpose  : Operand, result and handshake bundle between divider and its user.
// Revision : 1.0  initial release
// ============================================================================
interface div_32_if;
    import muldiv_pkg::*;

    logic             ctrl_div;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_div, data_operandA, data_operandB,
        input  data_result, data_remainder, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_div, data_operandA, data_operandB,
        output data_result, data_remainder, data_exception, data_resultRDY, busy
    );

endinterface
`default_nettype wire

// File: rtl/div_32_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One restoring-division step: trial subtract and quotient-bit select.
// Revision : 1.0  initial release
// ============================================================================
module div_step
    import muldiv_pkg::*;
(
    input  wire logic [WIDTH-1:0] rem_next,
    input  wire logic [WIDTH-1:0] abs_b,
    output logic      [WIDTH-1:0] rem_out,
    output logic                  q_bit
);

    logic [WIDTH:0] w_trial;

    assign w_trial = {1'b0, rem_next} - {1'b0, abs_b};
    assign q_bit   = ~w_trial[WIDTH];
    assign rem_out = q_bit ? w_trial[WIDTH-1:0] : rem_next;

endmodule
`default_nettype wire

// File: rtl/div_32.sv
`default_nettype none
// ============================================================================
// Module   : div_32
// Purpose  : Sequential 32-bit signed restoring divider, one quotient bit/cycle.
// Revision : 1.0  initial release
// ============================================================================
module div_32
    import muldiv_pkg::*;
(
    input  wire logic clock,
    input  wire logic reset_n,
    div_32_if.slave   bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-2:0]     r_rem;
    logic [WIDTH-1:0]     r_dq;
    logic [WIDTH-1:0]     r_absb;
    logic                 r_nega;
    logic                 r_negq;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_exception;
    logic                 r_rdy;

    logic                 w_load;
    logic                 w_fin_err;
    logic                 w_fin_ok;
    logic                 w_div0;
    logic                 w_ovf;
    logic                 w_err;
    logic                 w_last;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_rem_out;
    logic                 w_qbit;
    logic [WIDTH-1:0]     w_q_final;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_remd;

    assign w_abs_a = abs_val(bus.data_operandA);
    assign w_abs_b = abs_val(bus.data_operandB);
    assign w_div0  = (bus.data_operandB == '0);
    assign w_ovf   = (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
    assign w_err   = w_div0 | w_ovf;

    // The dividend and quotient share one shift register: dividend bits leave
    // at the top while quotient bits enter at the bottom.
    assign w_rem_next = {r_rem, r_dq[WIDTH-1]};

    div_step u_step (
        .rem_next (w_rem_next),
        .abs_b    (r_absb),
        .rem_out  (w_rem_out),
        .q_bit    (w_qbit)
    );

    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_q_final = {r_dq[WIDTH-2:0], w_qbit};
    assign w_quot    = r_negq ? neg(w_q_final) : w_q_final;
    assign w_remd    = r_nega ? neg(w_rem_out) : w_rem_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A start request restarts the datapath from any state, dropping an op in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_ok    = 1'b0;
        if (bus.ctrl_div) begin
            w_load      = 1'b1;
            w_fin_err   = w_err;
            w_state_nxt = w_err ? DONE : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_fin_ok    = 1'b1;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dq        <= '0;
            r_absb      <= '0;
            r_nega      <= 1'b0;
            r_negq      <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_rdy <= w_fin_err | w_fin_ok;

            if (w_load) begin
                r_cnt  <= '0;
                r_rem  <= '0;
                r_dq   <= w_abs_a;
                r_absb <= w_abs_b;
                r_nega <= bus.data_operandA[WIDTH-1];
                r_negq <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
                // Partial remainder stays below |B| <= 2^31, so its MSB is always zero.
                r_rem <= w_rem_out[WIDTH-2:0];
                r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
            end

            if (w_fin_err) begin
                r_result    <= w_div0 ? '0 : INT_MIN;
                r_remainder <= '0;
                r_exception <= 1'b1;
            end else if (w_fin_ok) begin
                r_result    <= w_quot;
                r_remainder <= w_remd;
                r_exception <= 1'b0;
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_remainder = r_remainder;
    assign bus.data_exception = r_exception;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = (r_state != IDLE);

endmodule
`default_nettype wire
